handshake_rr_arbiter: RTL
=========================

Name: handshake_rr_arbiter

Overview:
Round-robin arbiter that shares a single valid/ready sink between NUM_TX valid/ready sources.
- Output is a registered stage carrying the data and source index: 1-cycle latency, full throughput.
- Sits upstream of shared handshake consumers (combiners, FIFOs, buses) wherever several producers contend for one channel.
- Guarantees starvation-free access.

Parameters:
- NUM_TX, 4, number of requesting sources (>=1)
- DATA_WIDTH, 8, payload width per source
- SRC_W, (NUM_TX>1 ? $clog2(NUM_TX) : 1), width of source index (derived, not overridden)

Ports:
- clk_i  input  1  clock, all state on rising edge
- arst_i  input  1  asynchronous active-high reset
- tx_data_i  input  NUM_TX*DATA_WIDTH  packed payloads; source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- tx_valid_i  input  NUM_TX  per-source valid
- tx_ready_o  output  NUM_TX  per-source ready; at most one bit high
- rx_data_o  output  DATA_WIDTH  registered payload
- rx_src_o  output  SRC_W  index of source that produced rx_data_o
- rx_valid_o  output  1  registered valid
- rx_ready_i  input  1  sink ready

Interface: one clock (clk_i); reset arst_i is asynchronous and active-high.

Behaviour:
- Reset (arst_i high, asynchronous):
  - rx_valid_o=0, rx_data_o=0, rx_src_o=0, priority pointer ptr=0.
  - tx_ready_o=0 while arst_i is high.
  - A beat in flight is discarded.
- load = !rx_valid_o || rx_ready_i (output stage empty or draining this cycle).
- Grant logic (combinational):
  - Scan tx_valid_i starting at index ptr, ascending, wrapping at NUM_TX-1 -> 0.
  - First valid index found = winner w.
  - tx_ready_o[w] = load. All other tx_ready_o bits = 0.
- tx_ready_o may depend combinationally on tx_valid_i and rx_ready_i. It never depends on tx_data_i.
- Sources must hold valid and data stable until ready. The arbiter does not enforce this.
- Transfer (load && any tx_valid_i) at clock edge:
  - rx_data_o <= tx_data[w], rx_src_o <= w, rx_valid_o <= 1.
  - ptr <= (w==NUM_TX-1) ? 0 : w+1.
- load && no tx_valid_i: rx_valid_o <= 0. rx_data_o and rx_src_o hold their last values. ptr unchanged.
- !load (rx_valid_o=1, rx_ready_i=0): all outputs and ptr hold; all tx_ready_o = 0.
- Simultaneous drain and fill (rx_valid_o=1, rx_ready_i=1, source valid): old beat leaves and new beat is captured in the same edge. No bubble, so throughput is 1 beat/cycle.
- Latency: source handshake at edge N -> rx_valid_o high after edge N.
- Fairness: with all sources continuously valid, the grant order is 0,1,...,NUM_TX-1,0,... Any valid source is granted within NUM_TX transfers.
- NUM_TX=1: ptr is a constant 0, rx_src_o=0, and the block degenerates to a register slice.
- ptr wraps NUM_TX-1 -> 0. ptr never takes a value >= NUM_TX.

Optional Feature:
Macro HANDSHAKE_RR_ARBITER_LOCK_EN enables packet lock.
- Defined:
  - Adds input tx_last_i [NUM_TX] and output rx_last_o [1], registered alongside rx_data_o (reset 0).
  - FSM states: ARB (reset state) and LOCKED, plus a register lock_src.
  - ARB: grant as above. A transfer with tx_last_i[w]=0 -> lock_src<=w, go to LOCKED, ptr unchanged.
  - ARB: a transfer with tx_last_i[w]=1 -> stay in ARB, ptr advances.
  - LOCKED: only lock_src may be granted; other valids are ignored. A transfer with tx_last=1 -> go to ARB, ptr <= lock_src+1 (wrapped).
  - Reset in LOCKED -> state ARB.
- Undefined: no tx_last_i/rx_last_o ports; arbitration is per beat.

Test Plan:
- Reset mid-transfer: arst_i pulsed with rx_valid_o=1 -> rx_valid_o=0 immediately (before the next edge), ptr=0, tx_ready_o=0; the next grant goes to the lowest valid index.
- NUM_TX=4, all tx_valid_i=4'b1111, rx_ready_i=1 for 8 cycles -> rx_src_o sequence 0,1,2,3,0,1,2,3; one beat per cycle; rx_data_o matches the source.
- Backpressure: rx_ready_i=0 with rx_valid_o=1 for 5 cycles -> tx_ready_o=0, rx_data_o/rx_src_o stable. On release, the held beat drains and the next beat loads in the same cycle.
- Sparse requests: only source 2 valid, ptr=3 -> wrap scan grants 2, ptr becomes 3. Then sources 0 and 3 are valid -> 3 is granted first, then 0.
- Idle drain: single beat from source 1, then no valids, rx_ready_i=1 -> rx_valid_o high for exactly 1 cycle, then 0.
- LOCK_EN: source 0 sends 3 beats (last on the 3rd) while source 1 is valid throughout -> rx_src_o=0,0,0,1; tx_ready_o[1]=0 during the lock.

Source files
------------

// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter
//   Round-robin arbiter sharing one valid/ready sink between NUM_TX
//   valid/ready sources. The output is a registered slice: 1-cycle latency,
//   1 beat/cycle throughput.
//
// Ports
//   clk_i       clock, rising edge
//   arst_i      asynchronous active-high reset
//   tx_data_i   packed payloads, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   tx_valid_i  per-source valid
//   tx_ready_o  per-source ready, at most one bit high
//   tx_last_i   per-source end-of-packet (HANDSHAKE_RR_ARBITER_LOCK_EN only)
//   rx_data_o   registered payload
//   rx_src_o    index of the source that produced rx_data_o
//   rx_last_o   registered end-of-packet (HANDSHAKE_RR_ARBITER_LOCK_EN only)
//   rx_valid_o  registered valid
//   rx_ready_i  sink ready
//
// Optional feature: define HANDSHAKE_RR_ARBITER_LOCK_EN to keep the grant on
// one source from its first beat until its tx_last_i beat (packet lock).
module handshake_rr_arbiter #(
    parameter  int NUM_TX     = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int SRC_W      = (NUM_TX > 1) ? $clog2(NUM_TX) : 1
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic [NUM_TX*DATA_WIDTH-1:0] tx_data_i,
    input  logic [NUM_TX-1:0]            tx_valid_i,
    output logic [NUM_TX-1:0]            tx_ready_o,
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
    input  logic [NUM_TX-1:0]            tx_last_i,
    output logic                         rx_last_o,
`endif
    output logic [DATA_WIDTH-1:0]        rx_data_o,
    output logic [SRC_W-1:0]             rx_src_o,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i
);

    // Pointer successor, wrapping at NUM_TX-1 so ptr never leaves [0, NUM_TX).
    function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] w);
        return (int'(w) == NUM_TX - 1) ? '0 : w + 1'b1;
    endfunction

    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [SRC_W-1:0]      rx_src_q, rx_src_d;

    logic                  load;
    logic                  any_vld;
    logic [SRC_W-1:0]      win;
    logic                  xfer;

`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
    typedef enum logic {ARB, LOCKED} state_t;
    state_t                state_q, state_d;
    logic [SRC_W-1:0]      lock_src_q, lock_src_d;
    logic                  rx_last_q, rx_last_d;
`endif

    // Output stage can accept a beat when empty or draining this cycle.
    assign load = !rx_valid_q || rx_ready_i;

    // Winner: first valid source scanning upward from ptr with wrap.
    always_comb begin
        int idx;
        any_vld = 1'b0;
        win     = '0;
        idx     = 0;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
        if (state_q == LOCKED) begin
            any_vld = tx_valid_i[lock_src_q];
            win     = lock_src_q;
        end else
`endif
        begin
            for (int k = 0; k < NUM_TX; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_TX) idx = idx - NUM_TX;
                if (!any_vld && tx_valid_i[idx]) begin
                    any_vld = 1'b1;
                    win     = SRC_W'(idx);
                end
            end
        end
    end

    // Reset gating keeps ready low while the stage is held in reset (load
    // would otherwise be 1 because rx_valid_q is cleared).
    assign xfer = load && any_vld && !arst_i;

    always_comb begin
        tx_ready_o = '0;
        if (xfer) tx_ready_o[win] = 1'b1;
    end

    always_comb begin
        ptr_d      = ptr_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        rx_src_d   = rx_src_q;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
        state_d    = state_q;
        lock_src_d = lock_src_q;
        rx_last_d  = rx_last_q;
`endif
        if (load) begin
            rx_valid_d = any_vld;
            if (any_vld) begin
                rx_data_d = tx_data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                rx_src_d  = win;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
                rx_last_d = tx_last_i[win];
                case (state_q)
                    ARB: begin
                        if (tx_last_i[win]) begin
                            ptr_d = next_ptr(win);
                        end else begin
                            state_d    = LOCKED;
                            lock_src_d = win;
                        end
                    end
                    LOCKED: begin
                        if (tx_last_i[win]) begin
                            state_d = ARB;
                            ptr_d   = next_ptr(lock_src_q);
                        end
                    end
                    default: state_d = ARB;
                endcase
`else
                ptr_d = next_ptr(win);
`endif
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ptr_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_src_q   <= '0;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
            state_q    <= ARB;
            lock_src_q <= '0;
            rx_last_q  <= 1'b0;
`endif
        end else begin
            ptr_q      <= ptr_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_src_q   <= rx_src_d;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            rx_last_q  <= rx_last_d;
`endif
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign rx_src_o   = rx_src_q;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
    assign rx_last_o  = rx_last_q;
`endif

endmodule
